uart_nand_sequencer: RTL and testbench

Top-level sequencer between the UART byte link and `nand_controller`. It collects a framed 7-byte page-read command from the UART receiver and writes it into the shared page RAM. It then hands RAM ownership to `nand_controller` and raises its `ready`, waits for `comm_done` with a timeout, and streams the 2112 captured page bytes back out through the UART transmitter. It also arbitrates the single RAM port between itself and the NAND controller.

---
 rtl/uart_nand_sequencer_if.sv | 39 +++
 rtl/uart_nand_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_uart_nand_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_nand_sequencer_if.sv
// Bus bundle between the UART page sequencer and its surroundings: UART byte
// link, shared page RAM port, the NAND controller's RAM port and its handshake.
`timescale 1ns/1ps
interface uart_nand_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [11:0] nc_ram_addr;
    logic [7:0]  nc_ram_wdata;
    logic        nc_ram_we;
    logic [7:0]  nc_ram_rdata;
    logic        nand_ready;
    logic        nand_done;
    logic        page_done;
    logic        err;
    logic        rx_drop;

    // Sequencer side
    modport slave (
        input  rx_data, rx_valid, tx_busy, ram_rdata,
               nc_ram_addr, nc_ram_wdata, nc_ram_we, nand_done,
        output tx_data, tx_start, ram_addr, ram_wdata, ram_we,
               nc_ram_rdata, nand_ready, page_done, err, rx_drop
    );

    // Environment side (UART, RAM, NAND controller)
    modport master (
        output rx_data, rx_valid, tx_busy, ram_rdata,
               nc_ram_addr, nc_ram_wdata, nc_ram_we, nand_done,
        input  tx_data, tx_start, ram_addr, ram_wdata, ram_we,
               nc_ram_rdata, nand_ready, page_done, err, rx_drop
    );
endinterface

// File: rtl/uart_nand_sequencer.sv
// Page-read sequencer: collects an 0xA5-framed command from the UART into the
// shared RAM, lends the RAM to the NAND controller until it reports done (or
// the wait times out), then streams the captured page back out over the UART.
`timescale 1ns/1ps
module uart_nand_sequencer #(
    parameter int CMD_SIZE   = 7,
    parameter int DATA_BASE  = 8,
    parameter int PAGE_BYTES = 2112,
    parameter int TIMEOUT    = 1048576
) (
    input logic                   clk,
    input logic                   rst,
    uart_nand_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_CMD,
        S_START,
        S_NAND_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_TX_START,
        S_TX_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [7:0]  ERR_BYTE   = 8'hEE;
    localparam logic [2:0]  CMD_LAST   = 3'(CMD_SIZE - 1);
    localparam logic [11:0] DATA_START = 12'(DATA_BASE);
    // sent+1 == PAGE_BYTES is tested as sent == PAGE_BYTES-1 to stay in 12 bits
    localparam logic [11:0] SENT_LAST  = 12'(PAGE_BYTES - 1);
    localparam logic [20:0] TIMER_LAST = 21'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cmd_cnt_q, cmd_cnt_d;
    logic [11:0] rd_ptr_q, rd_ptr_d;
    logic [11:0] sent_q, sent_d;
    logic [20:0] timer_q, timer_d;
    logic        grant_q, grant_d;
    logic        nand_ready_q, nand_ready_d;
    logic [7:0]  tx_data_q, tx_data_d;

    // Sequencer's own RAM request and single-cycle strobes
    logic [11:0] seq_addr;
    logic [7:0]  seq_wdata;
    logic        seq_we;
    logic        tx_start;
    logic        page_done;
    logic        err;
    logic        rx_drop;

    // State and datapath registers, cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cmd_cnt_q    <= 3'd0;
            rd_ptr_q     <= 12'd0;
            sent_q       <= 12'd0;
            timer_q      <= 21'd0;
            grant_q      <= 1'b0;
            nand_ready_q <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            cmd_cnt_q    <= cmd_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            sent_q       <= sent_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            nand_ready_q <= nand_ready_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // Next-state and strobe decode for the command / NAND / stream sequence
    always_comb begin
        state_d      = state_q;
        cmd_cnt_d    = cmd_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        sent_d       = sent_q;
        timer_d      = timer_q;
        grant_d      = grant_q;
        nand_ready_d = nand_ready_q;
        tx_data_d    = tx_data_q;
        seq_addr     = 12'd0;
        seq_wdata    = 8'h00;
        seq_we       = 1'b0;
        tx_start     = 1'b0;
        page_done    = 1'b0;
        err          = 1'b0;
        // Only the two receiving states consume UART bytes; anything else is lost
        rx_drop      = bus.rx_valid && (state_q != S_IDLE) && (state_q != S_RX_CMD);

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    cmd_cnt_d = 3'd0;
                    state_d   = S_RX_CMD;
                end
            end

            S_RX_CMD: begin
                // No resync inside a frame: 0xA5 here is ordinary command data
                seq_addr = {9'd0, cmd_cnt_q};
                if (bus.rx_valid) begin
                    seq_we    = 1'b1;
                    seq_wdata = bus.rx_data;
                    cmd_cnt_d = cmd_cnt_q + 3'd1;
                    if (cmd_cnt_q == CMD_LAST) begin
                        // Hand over the RAM with the last write so ready shows
                        // up exactly one cycle after it
                        grant_d      = 1'b1;
                        nand_ready_d = 1'b1;
                        state_d      = S_START;
                    end
                end
            end

            S_START: begin
                grant_d      = 1'b1;
                nand_ready_d = 1'b1;
                timer_d      = 21'd0;
                state_d      = S_NAND_WAIT;
            end

            S_NAND_WAIT: begin
                timer_d = timer_q + 21'd1;
                // Done takes priority over a timeout landing in the same cycle
                if (bus.nand_done) begin
                    nand_ready_d = 1'b0;
                    grant_d      = 1'b0;
                    rd_ptr_d     = DATA_START;
                    sent_d       = 12'd0;
                    state_d      = S_RD_REQ;
                end else if (timer_q == TIMER_LAST) begin
                    nand_ready_d = 1'b0;
                    grant_d      = 1'b0;
                    tx_data_d    = ERR_BYTE;
                    state_d      = S_ERR;
                end
            end

            S_RD_REQ: begin
                seq_addr = rd_ptr_q;
                state_d  = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                // RAM read data arrives one cycle after the address
                tx_data_d = bus.ram_rdata;
                state_d   = S_TX_START;
            end

            S_TX_START: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_TX_WAIT;
                end
            end

            S_TX_WAIT: begin
                // tx_busy is already high on entry, so this waits for frame end
                if (!bus.tx_busy) begin
                    sent_d = sent_q + 12'd1;
                    if (sent_q == SENT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 12'd1;
                        state_d  = S_RD_REQ;
                    end
                end
            end

            S_DONE: begin
                page_done = 1'b1;
                state_d   = S_IDLE;
            end

            S_ERR: begin
                nand_ready_d = 1'b0;
                tx_data_d    = ERR_BYTE;
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    err      = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RAM port arbitration: the controller owns the port while granted
    assign bus.ram_addr     = grant_q ? bus.nc_ram_addr  : seq_addr;
    assign bus.ram_wdata    = grant_q ? bus.nc_ram_wdata : seq_wdata;
    assign bus.ram_we       = grant_q ? bus.nc_ram_we    : seq_we;
    assign bus.nc_ram_rdata = bus.ram_rdata;

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start;
    assign bus.nand_ready = nand_ready_q;
    assign bus.page_done  = page_done;
    assign bus.err        = err;
    assign bus.rx_drop    = rx_drop;

endmodule

// File: tb/tb_uart_nand_sequencer.sv
// Bench for uart_nand_sequencer: behavioural UART transmitter, registered RAM
// and a scripted NAND controller around the DUT; expected page streams come
// from the page image the bench itself loads and edits.
`timescale 1ns/1ps
module tb_uart_nand_sequencer;
    localparam int TMO  = 64;
    localparam int PAGE = 2112;
    localparam int BASE = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_nand_sequencer_if bus ();

    uart_nand_sequencer #(
        .CMD_SIZE  (7),
        .DATA_BASE (BASE),
        .PAGE_BYTES(PAGE),
        .TIMEOUT   (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Page image the bench intends the controller to have captured
    logic [7:0] page_img [PAGE];
    logic [7:0] cmd_bytes [7];
    logic       load_req = 1'b0;
    logic       hold_busy = 1'b0;

    // Registered-read RAM model
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < PAGE; i++) mem[BASE + i] <= page_img[i];
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // UART transmitter model: busy from the edge that takes tx_start for 1-2 cycles
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        else if (bus.tx_start) busy_cnt <= int'($urandom_range(2, 1));
    end
    assign bus.tx_busy = (busy_cnt != 0) || hold_busy;

    // Observers
    logic [7:0]  tx_q [$];
    logic [19:0] wr_q [$];
    int n_page = 0;
    int n_err = 0;
    int n_drop = 0;
    int ready_cyc = 0;
    always @(negedge clk) begin
        if (bus.tx_start) tx_q.push_back(bus.tx_data);
        if (bus.ram_we) wr_q.push_back({bus.ram_addr, bus.ram_wdata});
        if (bus.page_done) n_page <= n_page + 1;
        if (bus.err) n_err <= n_err + 1;
        if (bus.rx_drop) n_drop <= n_drop + 1;
        if (bus.nand_ready) ready_cyc <= ready_cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(2, 0)) tick();
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        send_byte(8'hA5);
        for (int i = 0; i < 7; i++) begin
            cmd_bytes[i] = 8'($urandom);
            send_byte(cmd_bytes[i]);
        end
    endtask

    task automatic load_page(input bit ramp);
        for (int i = 0; i < PAGE; i++)
            page_img[i] = ramp ? 8'((BASE + i) & 8'hFF) : 8'($urandom);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic pulse_done();
        bus.nand_done = 1'b1;
        tick();
        bus.nand_done = 1'b0;
    endtask

    task automatic wait_page(input int p0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            tick();
            if (n_page != p0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (tx_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
        n_cmp++; if (bus.nand_ready !== 1'b0) begin n_bad++; $display("FAIL reset_nand_ready: got %b expected 0", bus.nand_ready); end
        n_cmp++; if (bus.ram_addr !== 12'h000) begin n_bad++; $display("FAIL reset_ram_addr: got %h expected 000", bus.ram_addr); end
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we); end
        n_cmp++; if ({bus.page_done, bus.err, bus.rx_drop} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b expected 000", {bus.page_done, bus.err, bus.rx_drop}); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_normal_page();
        int q0, w0, p0, bad, fb, cnt;
        bit ok;
        logic [7:0] got;
        load_page(1'b1);
        q0 = tx_q.size(); w0 = wr_q.size(); p0 = n_page;
        send_byte(8'hA5);
        for (int i = 0; i < 6; i++) send_byte(8'h00);
        n_cmp++; if (bus.nand_ready !== 1'b0) begin n_bad++; $display("FAIL normal_ready_early: got %b expected 0", bus.nand_ready); end
        send_byte(8'h00);
        @(negedge clk);
        n_cmp++; if (bus.nand_ready !== 1'b1) begin n_bad++; $display("FAIL normal_ready_rise: got %b expected 1", bus.nand_ready); end
        bad = 0;
        if (wr_q.size() - w0 != 7) bad = 1;
        else for (int i = 0; i < 7; i++) if (wr_q[w0 + i] !== {12'(i), 8'h00}) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL normal_cmd_writes: got %0d writes (%0d bad) expected 7 at 0..6", wr_q.size() - w0, bad); end
        repeat (50) tick();
        n_cmp++; if (bus.nand_ready !== 1'b1) begin n_bad++; $display("FAIL normal_ready_hold: got %b expected 1", bus.nand_ready); end
        pulse_done();
        n_cmp++; if (bus.nand_ready !== 1'b0) begin n_bad++; $display("FAIL normal_ready_fall: got %b expected 0", bus.nand_ready); end
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h08) begin n_bad++; $display("FAIL normal_first_tx: got start=%b data=%h expected start=1 data=08", bus.tx_start, bus.tx_data); end
        wait_page(p0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL normal_page_wait: got no page_done expected one within budget"); end
        repeat (5) tick();
        cnt = tx_q.size() - q0;
        n_cmp++; if (cnt != PAGE) begin n_bad++; $display("FAIL normal_count: got %0d bytes expected %0d", cnt, PAGE); end
        got = (cnt >= PAGE) ? tx_q[q0 + PAGE - 1] : 8'hxx;
        n_cmp++; if (got !== 8'h47) begin n_bad++; $display("FAIL normal_last_byte: got %h expected 47", got); end
        bad = 0; fb = 0;
        for (int i = 0; i < PAGE && q0 + i < tx_q.size(); i++)
            if (tx_q[q0 + i] !== page_img[i]) begin if (bad == 0) fb = i; bad++; end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL normal_stream: got %0d wrong bytes (first idx %0d) expected 0", bad, fb); end
        n_cmp++; if (n_page - p0 != 1) begin n_bad++; $display("FAIL normal_page_done: got %0d pulses expected 1", n_page - p0); end
    endtask

    task automatic test_framing();
        int w0, d0, bad;
        load_page(1'b0);
        w0 = wr_q.size(); d0 = n_drop;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        repeat (3) tick();
        n_cmp++; if (wr_q.size() != w0) begin n_bad++; $display("FAIL framing_no_write: got %0d writes expected 0", wr_q.size() - w0); end
        n_cmp++; if (n_drop != d0) begin n_bad++; $display("FAIL framing_no_drop: got %0d drops expected 0", n_drop - d0); end
        send_byte(8'hA5);
        for (int i = 0; i < 7; i++) begin
            cmd_bytes[i] = (i == 2) ? 8'hA5 : 8'($urandom);
            send_byte(cmd_bytes[i]);
        end
        @(negedge clk);
        bad = 0;
        if (wr_q.size() - w0 != 7) bad = 1;
        else for (int i = 0; i < 7; i++) if (wr_q[w0 + i] !== {12'(i), cmd_bytes[i]}) bad++;
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL framing_cmd_writes: got %0d writes (%0d bad) expected 7 matching frame", wr_q.size() - w0, bad); end
        n_cmp++; if (bus.nand_ready !== 1'b1) begin n_bad++; $display("FAIL framing_ready: got %b expected 1", bus.nand_ready); end
    endtask

    task automatic test_arbitration();
        int q0, p0, bad, fb;
        bit ok;
        logic [7:0] d;
        logic [11:0] a;
        q0 = tx_q.size(); p0 = n_page;
        repeat (3) tick();
        d = 8'($urandom);
        bus.nc_ram_addr = 12'h010; bus.nc_ram_wdata = d; bus.nc_ram_we = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.ram_addr !== 12'h010 || bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL arb_mux: got addr=%h we=%b expected addr=010 we=1", bus.ram_addr, bus.ram_we); end
        n_cmp++; if (bus.ram_wdata !== d) begin n_bad++; $display("FAIL arb_wdata: got %h expected %h", bus.ram_wdata, d); end
        n_cmp++; if (bus.nc_ram_rdata !== bus.ram_rdata) begin n_bad++; $display("FAIL arb_rdata: got %h expected %h", bus.nc_ram_rdata, bus.ram_rdata); end
        page_img[12'h010 - BASE] = d;
        tick();
        for (int k = 0; k < 3; k++) begin
            a = 12'(BASE + $urandom_range(PAGE - 1, 0));
            d = 8'($urandom);
            bus.nc_ram_addr = a; bus.nc_ram_wdata = d;
            page_img[a - BASE] = d;
            tick();
        end
        bus.nc_ram_we = 1'b0;
        repeat (5) tick();
        pulse_done();
        wait_page(p0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL arb_page_wait: got no page_done expected one within budget"); end
        bad = 0; fb = 0;
        if (tx_q.size() - q0 != PAGE) bad = 1;
        else for (int i = 0; i < PAGE; i++) if (tx_q[q0 + i] !== page_img[i]) begin if (bad == 0) fb = i; bad++; end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL arb_stream: got %0d bytes with %0d bad (idx %0d) expected %0d matching", tx_q.size() - q0, bad, fb, PAGE); end
    endtask

    task automatic test_back_to_back();
        int q0, p0, d0, s, bad, fb;
        bit ok;
        load_page(1'b0);
        q0 = tx_q.size(); p0 = n_page; d0 = n_drop;
        send_frame();
        repeat (30) tick();
        pulse_done();
        wait_bytes(q0 + 100, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_stream_start: got %0d bytes expected >=100", tx_q.size() - q0); end
        bus.rx_data = 8'($urandom); bus.rx_valid = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.rx_drop !== 1'b1) begin n_bad++; $display("FAIL bp_rx_drop: got %b expected 1", bus.rx_drop); end
        tick();
        bus.rx_valid = 1'b0;
        hold_busy = 1'b1;
        tick();
        s = tx_q.size();
        repeat (200) tick();
        n_cmp++; if (tx_q.size() != s) begin n_bad++; $display("FAIL bp_hold: got %0d starts while busy expected 0", tx_q.size() - s); end
        hold_busy = 1'b0;
        wait_page(p0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_page_wait: got no page_done expected one within budget"); end
        bad = 0; fb = 0;
        if (tx_q.size() - q0 != PAGE) bad = 1;
        else for (int i = 0; i < PAGE; i++) if (tx_q[q0 + i] !== page_img[i]) begin if (bad == 0) fb = i; bad++; end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_stream: got %0d bytes with %0d bad (idx %0d) expected %0d in order", tx_q.size() - q0, bad, fb, PAGE); end
        n_cmp++; if (n_drop - d0 != 1) begin n_bad++; $display("FAIL bp_drop_count: got %0d expected 1", n_drop - d0); end
    endtask

    task automatic test_timeout();
        int q0, e0, p0, r0, hi;
        bit ok;
        q0 = tx_q.size(); e0 = n_err; p0 = n_page; r0 = ready_cyc;
        send_frame();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (n_err != e0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout_err_wait: got no err expected one within budget"); end
        hi = ready_cyc - r0;
        n_cmp++; if (hi < TMO || hi > TMO + 2) begin n_bad++; $display("FAIL timeout_ready_len: got %0d cycles expected %0d..%0d", hi, TMO, TMO + 2); end
        n_cmp++; if (bus.nand_ready !== 1'b0) begin n_bad++; $display("FAIL timeout_ready_low: got %b expected 0", bus.nand_ready); end
        repeat (10) tick();
        n_cmp++; if (tx_q.size() - q0 != 1 || tx_q[tx_q.size() - 1] !== 8'hEE) begin n_bad++; $display("FAIL timeout_ee: got %0d bytes last=%h expected 1 byte EE", tx_q.size() - q0, tx_q[tx_q.size() - 1]); end
        n_cmp++; if (n_err - e0 != 1 || n_page != p0) begin n_bad++; $display("FAIL timeout_pulses: got err=%0d page=%0d expected err=1 page=0", n_err - e0, n_page - p0); end
    endtask

    task automatic test_reset_mid();
        int q0, s;
        bit ok;
        load_page(1'b0);
        q0 = tx_q.size();
        send_frame();
        @(negedge clk);
        n_cmp++; if (bus.nand_ready !== 1'b1) begin n_bad++; $display("FAIL post_timeout_frame: got ready=%b expected 1", bus.nand_ready); end
        repeat (20) tick();
        pulse_done();
        wait_bytes(q0 + 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_stream_start: got %0d bytes expected >=20", tx_q.size() - q0); end
        rst = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++; if ({bus.tx_start, bus.nand_ready, bus.ram_we, bus.page_done, bus.err} !== 5'b0) begin n_bad++; $display("FAIL rmid_ctrl: got %b expected 00000", {bus.tx_start, bus.nand_ready, bus.ram_we, bus.page_done, bus.err}); end
        n_cmp++; if (bus.tx_data !== 8'h00 || bus.ram_addr !== 12'h000) begin n_bad++; $display("FAIL rmid_data: got tx_data=%h ram_addr=%h expected 00/000", bus.tx_data, bus.ram_addr); end
        tick(); tick();
        rst = 1'b1;
        s = tx_q.size();
        repeat (100) tick();
        n_cmp++; if (tx_q.size() != s) begin n_bad++; $display("FAIL rmid_no_tx: got %0d starts after reset expected 0", tx_q.size() - s); end
        send_frame();
        @(negedge clk);
        n_cmp++; if (bus.nand_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_relaunch: got ready=%b expected 1", bus.nand_ready); end
    endtask

    initial begin
        rst              = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rx_valid     = 1'b0;
        bus.nc_ram_addr  = 12'h000;
        bus.nc_ram_wdata = 8'h00;
        bus.nc_ram_we    = 1'b0;
        bus.nand_done    = 1'b0;
        test_reset();
        test_normal_page();
        test_framing();
        test_arbitration();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
